pixel_array_gray_counter: RTL and testbench

Parametrised conversion-ramp counter for the digital pixel sensor array. On a start pulse it drives a WIDTH-bit Gray-coded (or binary) count onto the shared pixel DATA bus, stepping once every DIV clocks, up or down, then either stops at a terminal value or wraps continuously. Outside a conversion it releases the bus to high-Z so pixels can drive it during readout. It replaces the fixed 8-bit free-running array counter.

---
 rtl/pixel_array_gray_counter.sv | 113 +++++++++++
 tb/tb_pixel_array_gray_counter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_gray_counter.sv
// Conversion-ramp counter for the pixel array: drives a Gray or binary count onto the
// shared DATA bus during a ramp and releases the bus to high-Z otherwise.
module pixel_array_gray_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int DIV       = 1,
    parameter bit GRAY      = 1'b1
) (
    input  logic             COUNTER_CLOCK,
    input  logic             COUNTER_RESET,
    input  logic             COUNTER_START,
    input  logic             COUNTER_ABORT,
    input  logic             COUNTER_DOWN,
    input  logic             COUNTER_WRAP,
    inout  wire  [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] COUNT_BIN,
    output logic             COUNTER_BUSY,
    output logic             COUNTER_DONE,
    output logic [1:0]       COUNTER_STATE
);

    localparam int               DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);
    localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic             down_q;
    logic             wrap_q;
    logic [WIDTH-1:0] enc_q;
    logic [WIDTH-1:0] launch_val;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] step_val;

    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b);
        return GRAY ? (b ^ (b >> 1)) : b;
    endfunction

    // launch_val uses the live DOWN input; the others use the direction latched at START.
    always_comb begin
        launch_val = COUNTER_DOWN ? MAX_C : '0;
        start_val  = down_q ? MAX_C : '0;
        term_val   = down_q ? '0 : MAX_C;
        step_val   = down_q ? (COUNT_BIN - WIDTH'(1)) : (COUNT_BIN + WIDTH'(1));
    end

    always_ff @(posedge COUNTER_CLOCK) begin
        if (COUNTER_RESET) begin
            state        <= IDLE;
            COUNT_BIN    <= '0;
            div_cnt      <= '0;
            down_q       <= 1'b0;
            wrap_q       <= 1'b0;
            enc_q        <= '0;
            COUNTER_BUSY <= 1'b0;
            COUNTER_DONE <= 1'b0;
        end else begin
            COUNTER_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (COUNTER_START) begin
                        down_q       <= COUNTER_DOWN;
                        wrap_q       <= COUNTER_WRAP;
                        COUNT_BIN    <= launch_val;
                        enc_q        <= encode(launch_val);
                        div_cnt      <= '0;
                        state        <= RUN;
                        COUNTER_BUSY <= 1'b1;
                    end
                end
                RUN: begin
                    if (COUNTER_ABORT) begin
                        state        <= IDLE;
                        COUNTER_BUSY <= 1'b0;
                        div_cnt      <= '0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        // A step at the terminal value either reloads or ends the ramp; never rolls over.
                        if (COUNT_BIN != term_val) begin
                            COUNT_BIN <= step_val;
                            enc_q     <= encode(step_val);
                        end else if (wrap_q) begin
                            COUNT_BIN <= start_val;
                            enc_q     <= encode(start_val);
                        end else begin
                            state        <= DONE;
                            COUNTER_BUSY <= 1'b0;
                            COUNTER_DONE <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign COUNTER_STATE = state;

    // Bus enable comes straight from a flop so the release edge matches BUSY falling.
    assign DATA = COUNTER_BUSY ? enc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_pixel_array_gray_counter.sv
// Bench for pixel_array_gray_counter: three parameterisations driven against a
// queue-based ramp model, with a pixel-side driver that fills the bus whenever it is released.
module tb_pixel_array_gray_counter;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v, abort_v, down_v, wrap_v, pix_en;
    logic [7:0] pix_val;
    wire  [7:0] data0;
    wire  [3:0] data1, data2;
    logic [7:0] cnt0;
    logic [3:0] cnt1, cnt2;
    logic [2:0] busy_v, done_v;
    logic [1:0] st0, st1, st2;

    assign data0 = pix_en[0] ? pix_val : 8'bz;
    assign data1 = pix_en[1] ? pix_val[3:0] : 4'bz;
    assign data2 = pix_en[2] ? pix_val[3:0] : 4'bz;

    pixel_array_gray_counter u0 (
        .COUNTER_CLOCK(clk), .COUNTER_RESET(rst), .COUNTER_START(start_v[0]),
        .COUNTER_ABORT(abort_v[0]), .COUNTER_DOWN(down_v[0]), .COUNTER_WRAP(wrap_v[0]),
        .DATA(data0), .COUNT_BIN(cnt0), .COUNTER_BUSY(busy_v[0]), .COUNTER_DONE(done_v[0]),
        .COUNTER_STATE(st0)
    );

    pixel_array_gray_counter #(.WIDTH(4), .MAX_COUNT(9), .DIV(2), .GRAY(1'b0)) u1 (
        .COUNTER_CLOCK(clk), .COUNTER_RESET(rst), .COUNTER_START(start_v[1]),
        .COUNTER_ABORT(abort_v[1]), .COUNTER_DOWN(down_v[1]), .COUNTER_WRAP(wrap_v[1]),
        .DATA(data1), .COUNT_BIN(cnt1), .COUNTER_BUSY(busy_v[1]), .COUNTER_DONE(done_v[1]),
        .COUNTER_STATE(st1)
    );

    pixel_array_gray_counter #(.WIDTH(4), .MAX_COUNT(5), .DIV(1), .GRAY(1'b1)) u2 (
        .COUNTER_CLOCK(clk), .COUNTER_RESET(rst), .COUNTER_START(start_v[2]),
        .COUNTER_ABORT(abort_v[2]), .COUNTER_DOWN(down_v[2]), .COUNTER_WRAP(wrap_v[2]),
        .DATA(data2), .COUNT_BIN(cnt2), .COUNTER_BUSY(busy_v[2]), .COUNTER_DONE(done_v[2]),
        .COUNTER_STATE(st2)
    );

    int         max_c [3];
    int         div_c [3];
    bit         gray_c[3];
    logic [7:0] mask_c[3];
    logic [7:0] saved_cnt[3];

    int         sel;
    int         checks;
    int         failures;
    int         m_state;
    logic [7:0] m_count;
    bit         m_down, m_wrap;
    logic [7:0] exp_q[$];
    logic       exp_busy, exp_done;
    logic [7:0] exp_data;

    logic [7:0] cur_count, cur_data;
    logic       cur_busy, cur_done;
    logic [1:0] cur_state;

    always_comb begin
        cur_count = cnt0;
        cur_data  = data0;
        cur_busy  = busy_v[0];
        cur_done  = done_v[0];
        cur_state = st0;
        if (sel == 1) begin
            cur_count = {4'b0, cnt1};
            cur_data  = {4'b0, data1};
            cur_busy  = busy_v[1];
            cur_done  = done_v[1];
            cur_state = st1;
        end else if (sel == 2) begin
            cur_count = {4'b0, cnt2};
            cur_data  = {4'b0, data2};
            cur_busy  = busy_v[2];
            cur_done  = done_v[2];
            cur_state = st2;
        end
    end

    function automatic logic [7:0] enc(input logic [7:0] b);
        return gray_c[sel] ? (b ^ (b >> 1)) : b;
    endfunction

    // Full ramp as the list of values seen on consecutive BUSY cycles.
    function automatic void fill_ramp();
        for (int k = 0; k <= max_c[sel]; k++)
            for (int d = 0; d < div_c[sel]; d++)
                exp_q.push_back(8'(m_down ? (max_c[sel] - k) : k));
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit a, input bit d, input bit w);
        if (r) begin
            m_state = M_IDLE;
            m_count = 8'd0;
            m_down  = 1'b0;
            m_wrap  = 1'b0;
            exp_q.delete();
        end else if (m_state == M_IDLE) begin
            if (s) begin
                m_down = d;
                m_wrap = w;
                fill_ramp();
                m_count = exp_q.pop_front();
                m_state = M_RUN;
            end
        end else if (m_state == M_RUN) begin
            if (a) begin
                m_state = M_IDLE;
                exp_q.delete();
            end else if (exp_q.size() == 0) begin
                if (m_wrap) begin
                    fill_ramp();
                    m_count = exp_q.pop_front();
                end else begin
                    m_state = M_DONE;
                end
            end else begin
                m_count = exp_q.pop_front();
            end
        end else begin
            m_state = M_IDLE;
        end
    endfunction

    task automatic select(input int k);
        saved_cnt[sel] = m_count;
        sel = k;
        m_count = saved_cnt[k];
        #1;
    endtask

    task automatic tick(input bit r, input bit s, input bit a, input bit d, input bit w);
        rst     = r;
        start_v = '0; abort_v = '0; down_v = '0; wrap_v = '0;
        start_v[sel] = s; abort_v[sel] = a; down_v[sel] = d; wrap_v[sel] = w;
        @(posedge clk);
        model_step(r, s, a, d, w);
        #1;
        pix_en = '1;
        if (m_state == M_RUN) pix_en[sel] = 1'b0;
        pix_val  = 8'($urandom);
        exp_busy = (m_state == M_RUN);
        exp_done = (m_state == M_DONE);
        exp_data = exp_busy ? enc(m_count) : (pix_val & mask_c[sel]);
        #1;
    endtask

    task automatic test_reset();
        select(0);
        for (int i = 0; i < 2; i++)
            tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 3; k++) begin
            select(k);
            checks++;
            if ({cur_busy, cur_done, cur_count, cur_data, cur_state} !==
                {1'b0, 1'b0, 8'd0, pix_val & mask_c[k], 2'd0}) begin
                failures++;
                $display("FAIL reset inst=%0d got busy=%b done=%b cnt=%0d data=%h st=%0d exp 0 0 0 data=%h st=0",
                         k, cur_busy, cur_done, cur_count, cur_data, cur_state, pix_val & mask_c[k]);
            end
        end
        select(0);
    endtask

    task automatic test_up_ramp();
        int busy_n = 0;
        int done_n = 0;
        logic [7:0] prev = 8'd0;
        bit prev_busy = 1'b0;
        select(0);
        for (int i = 0; i < 258; i++) begin
            tick(1'b0, i == 0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({cur_busy, cur_done, cur_count, cur_data} !== {exp_busy, exp_done, m_count, exp_data}) begin
                failures++;
                $display("FAIL up_ramp cyc=%0d got busy=%b done=%b cnt=%0d data=%h exp busy=%b done=%b cnt=%0d data=%h",
                         i, cur_busy, cur_done, cur_count, cur_data, exp_busy, exp_done, m_count, exp_data);
            end
            if (i == 3) begin
                checks++;
                if (cur_data !== 8'h02) begin
                    failures++;
                    $display("FAIL up_ramp_third_step got=%h exp=02", cur_data);
                end
            end
            if (i == 255) begin
                checks++;
                if (cur_data !== 8'h80) begin
                    failures++;
                    $display("FAIL up_ramp_last got=%h exp=80", cur_data);
                end
            end
            if (cur_busy && prev_busy) begin
                checks++;
                if ($countones(cur_data ^ prev) != 1) begin
                    failures++;
                    $display("FAIL gray_adjacent cyc=%0d prev=%h cur=%h", i, prev, cur_data);
                end
            end
            if (cur_busy) busy_n++;
            if (cur_done) done_n++;
            prev = cur_data;
            prev_busy = cur_busy;
        end
        checks++;
        if (busy_n != 256) begin
            failures++;
            $display("FAIL up_ramp_busy_len got=%0d exp=256", busy_n);
        end
        checks++;
        if (done_n != 1) begin
            failures++;
            $display("FAIL up_ramp_done_pulses got=%0d exp=1", done_n);
        end
    endtask

    task automatic test_down_div();
        int busy_n = 0;
        int done_n = 0;
        select(1);
        for (int i = 0; i < 23; i++) begin
            tick(1'b0, i == 0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({cur_busy, cur_done, cur_count, cur_data} !== {exp_busy, exp_done, m_count, exp_data}) begin
                failures++;
                $display("FAIL down_div cyc=%0d got busy=%b done=%b cnt=%0d data=%h exp busy=%b done=%b cnt=%0d data=%h",
                         i, cur_busy, cur_done, cur_count, cur_data, exp_busy, exp_done, m_count, exp_data);
            end
            if (cur_count > 8'd9) begin
                failures++;
                $display("FAIL down_div_range cyc=%0d got=%0d exp<=9", i, cur_count);
            end
            if (cur_busy) busy_n++;
            if (cur_done) done_n++;
        end
        checks++;
        if (busy_n != 20 || done_n != 1) begin
            failures++;
            $display("FAIL down_div_len got busy=%0d done=%0d exp busy=20 done=1", busy_n, done_n);
        end
    endtask

    task automatic test_wrap();
        select(2);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, i == 0, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({cur_busy, cur_done, cur_count, cur_data} !== {exp_busy, exp_done, m_count, exp_data}) begin
                failures++;
                $display("FAIL wrap cyc=%0d got busy=%b done=%b cnt=%0d data=%h exp busy=%b done=%b cnt=%0d data=%h",
                         i, cur_busy, cur_done, cur_count, cur_data, exp_busy, exp_done, m_count, exp_data);
            end
            if (i == 6) begin
                checks++;
                if (cur_count !== 8'd0 || cur_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_reload got cnt=%0d busy=%b exp cnt=0 busy=1", cur_count, cur_busy);
                end
            end
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({cur_busy, cur_done, cur_data} !== {1'b0, 1'b0, pix_val & mask_c[2]}) begin
            failures++;
            $display("FAIL wrap_abort got busy=%b done=%b data=%h exp busy=0 done=0 data=%h",
                     cur_busy, cur_done, cur_data, pix_val & mask_c[2]);
        end
    endtask

    task automatic test_ignored_and_abort();
        select(0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 300 && m_count != 8'd100; n++) begin
            tick(1'b0, (m_count == 8'd10) || 1'($urandom_range(0, 1)), 1'b0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if ({cur_busy, cur_done, cur_count, cur_data} !== {exp_busy, exp_done, m_count, exp_data}) begin
                failures++;
                $display("FAIL ignored_inputs cyc=%0d got busy=%b done=%b cnt=%0d data=%h exp busy=%b done=%b cnt=%0d data=%h",
                         n, cur_busy, cur_done, cur_count, cur_data, exp_busy, exp_done, m_count, exp_data);
            end
        end
        checks++;
        if (m_count != 8'd100) begin
            failures++;
            $display("FAIL ignored_timeout got=%0d exp=100", m_count);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({cur_busy, cur_done, cur_count, cur_data} !== {1'b0, 1'b0, 8'd100, pix_val}) begin
            failures++;
            $display("FAIL abort_at_100 got busy=%b done=%b cnt=%0d data=%h exp busy=0 done=0 cnt=100 data=%h",
                     cur_busy, cur_done, cur_count, cur_data, pix_val);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({cur_busy, cur_done, cur_count} !== {1'b0, 1'b0, 8'd100}) begin
                failures++;
                $display("FAIL abort_idle cyc=%0d got busy=%b done=%b cnt=%0d exp 0 0 100", i, cur_busy, cur_done, cur_count);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({cur_busy, cur_count, cur_data} !== {1'b1, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL restart got busy=%b cnt=%0d data=%h exp busy=1 cnt=0 data=00", cur_busy, cur_count, cur_data);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        select(0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 100 && m_count != 8'd37; n++)
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cur_count !== 8'd37 || cur_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_reach got cnt=%0d busy=%b exp cnt=37 busy=1", cur_count, cur_busy);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({cur_busy, cur_done, cur_count, cur_data} !== {1'b0, 1'b0, 8'd0, pix_val}) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b cnt=%0d data=%h exp busy=0 done=0 cnt=0 data=%h",
                     cur_busy, cur_done, cur_count, cur_data, pix_val);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort_terminal();
        select(1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++)
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({cur_busy, cur_done, cur_count, cur_data} !== {1'b0, 1'b0, 8'd9, pix_val & 8'h0f}) begin
            failures++;
            $display("FAIL abort_terminal got busy=%b done=%b cnt=%0d data=%h exp busy=0 done=0 cnt=9 data=%h",
                     cur_busy, cur_done, cur_count, cur_data, pix_val & 8'h0f);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (cur_done !== 1'b0 || cur_busy !== 1'b0) begin
                failures++;
                $display("FAIL abort_terminal_after cyc=%0d got done=%b busy=%b exp 0 0", i, cur_done, cur_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        int ramps = 0;
        select(1);
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({cur_busy, cur_done, cur_count, cur_data} !== {exp_busy, exp_done, m_count, exp_data}) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got busy=%b done=%b cnt=%0d data=%h exp busy=%b done=%b cnt=%0d data=%h",
                         i, cur_busy, cur_done, cur_count, cur_data, exp_busy, exp_done, m_count, exp_data);
            end
            if (!cur_busy) begin
                gap++;
            end else begin
                if (gap != 0) begin
                    ramps++;
                    checks++;
                    if (gap != 2) begin
                        failures++;
                        $display("FAIL back_to_back_gap got=%0d exp=2", gap);
                    end
                end
                gap = 0;
            end
        end
        checks++;
        if (ramps != 2) begin
            failures++;
            $display("FAIL back_to_back_restarts got=%0d exp=2", ramps);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start_v = '0; abort_v = '0; down_v = '0; wrap_v = '0;
        pix_en = '1;
        pix_val = 8'd0;
        max_c  = '{255, 9, 5};
        div_c  = '{1, 2, 1};
        gray_c = '{1'b1, 1'b0, 1'b1};
        mask_c = '{8'hff, 8'h0f, 8'h0f};
        saved_cnt = '{8'd0, 8'd0, 8'd0};
        sel = 0;
        checks = 0;
        failures = 0;
        m_state = M_IDLE;
        m_count = 8'd0;
        m_down = 1'b0;
        m_wrap = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_data = 8'd0;

        test_reset();
        test_up_ramp();
        test_down_div();
        test_wrap();
        test_ignored_and_abort();
        test_reset_mid();
        test_abort_terminal();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
